btn_debounce: RTL and testbench

Conditions a raw, asynchronous, bouncy push-button into a clean, synchronous level. It is the stage directly upstream of the rising-edge pulse generator: btn_out drives that block's w input, which in turn produces the single-cycle start pulse for the signed serial-parallel multiplier. The block contains a multi-flop synchronizer, followed by a 4-state debounce FSM with a stability counter.

---
 rtl/btn_debounce.sv | 126 ++++++++++++
 tb/tb_btn_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: multi-flop synchronizer plus a 4-state debounce FSM.
// Optional DEBOUNCE_STATUS_EN adds pending/glitch status outputs.
module btn_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
`ifdef DEBOUNCE_STATUS_EN
  ,
  output logic pending,
  output logic glitch
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      STABLE_LO: begin
        cnt_nx = '0;
        if (s) begin
          if (ONE_SHOT) begin
            state_nx = STABLE_HI;
          end else begin
            state_nx = PEND_HI;
            cnt_nx   = ONE;
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      STABLE_HI: begin
        cnt_nx = '0;
        if (!s) begin
          if (ONE_SHOT) begin
            state_nx = STABLE_LO;
          end else begin
            state_nx = PEND_LO;
            cnt_nx   = ONE;
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // Decoded from registered state only; rst gating is the sole combinational term.
  assign btn_out = !rst &&
    (state == STABLE_HI || state == PEND_LO);

`ifdef DEBOUNCE_STATUS_EN
  logic abort;

  assign abort = (state == PEND_HI && !s) ||
                 (state == PEND_LO && s);

  assign pending = !rst &&
    (state == PEND_HI || state == PEND_LO);

  always_ff @(posedge clk) begin
    if (rst) glitch <= 1'b0;
    else     glitch <= abort;
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (SYNC_STAGES=2, STABLE_CYCLES=4).
// Latency from input change to btn_out change is 6 edges.
module tb_btn_debounce;

  localparam int SS = 2;
  localparam int SC = 4;
  localparam int CW = 4;
  localparam int LAT = SS + SC;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_out;
`ifdef DEBOUNCE_STATUS_EN
  logic pending;
  logic glitch;
`endif

  int vecs  = 0;
  int fails = 0;
  int gcnt  = 0;
  int zcnt  = 0;
  logic w_d = 1'b0;
  int base;

  always #5 clk = ~clk;

  btn_debounce #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .btn_out(btn_out)
`ifdef DEBOUNCE_STATUS_EN
    ,
    .pending(pending),
    .glitch (glitch)
`endif
  );

  // Downstream rising-edge detector model fed by btn_out (its w input).
  always @(posedge clk) begin
    w_d <= btn_out;
    if (btn_out === 1'b1 && w_d === 1'b0) zcnt <= zcnt + 1;
  end

`ifdef DEBOUNCE_STATUS_EN
  always @(posedge clk) begin
    if (glitch === 1'b1) gcnt <= gcnt + 1;
  end
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_edge(input string tag, input logic lvl);
    for (int k = 1; k <= LAT; k++) begin
      step();
      check(tag, 32'(btn_out), 32'((k >= LAT) ? lvl : !lvl));
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b1;
    #1;
    check("rst_comb", 32'(btn_out), 32'(0));

    // 1: reset held with button pressed
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_hold", 32'(btn_out), 32'(0));
    end
    rst = 1'b0;
    expect_edge("rst_release_rise", 1'b1);

    // 2: clean release then clean press
    btn_in = 1'b0;
    expect_edge("clean_fall", 1'b0);
    btn_in = 1'b1;
    expect_edge("clean_rise", 1'b1);
    btn_in = 1'b0;
    expect_edge("clean_fall2", 1'b0);
    repeat (3) step();

    // 3: bounce 1,0,1,0 then hold 1
    base = gcnt;
    btn_in = 1'b1; step();
    check("bounce_lo", 32'(btn_out), 32'(0));
    btn_in = 1'b0; step();
    check("bounce_lo", 32'(btn_out), 32'(0));
    btn_in = 1'b1; step();
    check("bounce_lo", 32'(btn_out), 32'(0));
    btn_in = 1'b0; step();
    check("bounce_lo", 32'(btn_out), 32'(0));
    btn_in = 1'b1;
    expect_edge("bounce_rise", 1'b1);
`ifdef DEBOUNCE_STATUS_EN
    check("bounce_glitches", 32'(gcnt - base), 32'(2));
`endif
    btn_in = 1'b0;
    expect_edge("bounce_fall", 1'b0);
    repeat (3) step();

    // 4: three-cycle pulse is rejected
    base = gcnt;
    btn_in = 1'b1;
    repeat (3) step();
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("short_pulse", 32'(btn_out), 32'(0));
    end
`ifdef DEBOUNCE_STATUS_EN
    check("short_glitch", 32'(gcnt - base), 32'(1));
    check("short_pend_idle", 32'(pending), 32'(0));
`endif

    // 5: reset while PEND_HI with cnt = 2
    btn_in = 1'b1;
    repeat (4) step();
    check("pend_cnt2", 32'(dut.cnt), 32'(2));
`ifdef DEBOUNCE_STATUS_EN
    check("pend_flag", 32'(pending), 32'(1));
`endif
    rst = 1'b1;
    #1;
    check("midrst_out", 32'(btn_out), 32'(0));
`ifdef DEBOUNCE_STATUS_EN
    check("midrst_pend", 32'(pending), 32'(0));
`endif
    step();
    check("midrst_cnt", 32'(dut.cnt), 32'(0));
    check("midrst_out2", 32'(btn_out), 32'(0));
    rst = 1'b0;
    expect_edge("midrst_rise", 1'b1);
    btn_in = 1'b0;
    expect_edge("midrst_fall", 1'b0);
    repeat (3) step();

    // 6: bouncy press/release -> one downstream z pulse
    base = zcnt;
    btn_in = 1'b1; step();
    btn_in = 1'b0; step();
    btn_in = 1'b1; step();
    step();
    btn_in = 1'b0; step();
    btn_in = 1'b1;
    repeat (12) step();
    check("chain_level_hi", 32'(btn_out), 32'(1));
    btn_in = 1'b0; step();
    btn_in = 1'b1; step();
    btn_in = 1'b0;
    repeat (12) step();
    check("chain_level_lo", 32'(btn_out), 32'(0));
    check("chain_z_pulses", 32'(zcnt - base), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
